win_frame_reader: RTL and testbench
===================================

Name: win_frame_reader

Overview:
- Consumer side of the STFT framing buffer.
- Waits for a frame from the window buffer, then reads all WIN_LEN samples in address order through that buffer's combinational read port.
- Multiplies each sample by a periodic Hann coefficient and streams the windowed frame to the FFT front end over a valid/ready interface.
- Asserts read_en for exactly one cycle after the frame is fully consumed, which releases the buffer for the next hop.

Parameters:
- DATA_WIDTH, 16, signed sample width, input and output.
- WIN_LEN, 480, samples per frame.
- COEF_WIDTH, 16, unsigned window coefficient width, format Q1.(COEF_WIDTH-1); 1.0 = 2^(COEF_WIDTH-1).
- ADDR_WIDTH, $clog2(WIN_LEN), read address width.
- FRAME_CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows new frames to start; sampled only in IDLE.
- frame_available  in  1  buffer holds a fresh frame.
- buffer_ready  in  1  buffer holds a full window; sticky once set.
- buf_data  in  DATA_WIDTH  combinational buffer output for read_addr.
- read_en  out  1  one-cycle release pulse to the buffer.
- read_addr  out  ADDR_WIDTH  buffer read address.
- m_data  out  DATA_WIDTH  windowed sample, signed.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  marks sample WIN_LEN-1 of the frame.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  FRAME_CNT_WIDTH  count of released frames; wraps.

Behaviour:
- Reset (async, rst=1) puts the block in IDLE:
  - read_en=0, read_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_count=0.
  - All pipeline valid bits cleared.
- FSM states: IDLE, READ, DRAIN, RELEASE.
  - IDLE -> READ when enable && frame_available && buffer_ready. read_addr=0 on entry.
  - READ:
    - Presents read_addr; advances it by 1 on each cycle the pipeline advances.
    - After address WIN_LEN-1 is issued, goes to DRAIN.
  - DRAIN: waits until the beam with m_last is accepted (m_valid && m_ready && m_last), then goes to RELEASE.
  - RELEASE:
    - read_en=1 for exactly this cycle; frame_count increments.
    - Goes to IDLE; read_addr returns to 0.
- read_en is never asserted during READ or DRAIN. The buffer therefore cannot shift new samples in while a frame is being read.
- Pipeline advance condition: adv = !m_valid || m_ready.
  - Stage 1 registers: buf_data, the ROM coefficient for read_addr, and the last flag.
  - Stage 2 registers: the product, m_valid and m_last.
  - When adv=0, read_addr and both stages hold.
- Latency: address presented in cycle t gives m_valid in cycle t+2 with no stall.
  - First m_valid appears 3 cycles after the IDLE cycle that detects the start condition.
  - Throughput is 1 sample per cycle while m_ready=1.
- m_data is held stable while m_valid && !m_ready (AXI-style; no drop, no duplicate).
- Arithmetic:
  - p = signed(buf_data) * unsigned(coef), full width DATA_WIDTH+COEF_WIDTH+1.
  - Add 2^(COEF_WIDTH-2), then arithmetic right shift by COEF_WIDTH-1. This rounds half toward +inf.
  - Saturate to the signed DATA_WIDTH range.
- Coefficients: coef[n] = round(2^(COEF_WIDTH-1) * (0.5 - 0.5*cos(2*pi*n/WIN_LEN))), n = 0..WIN_LEN-1 (periodic Hann).
  - coef[0]=0.
  - Computed at elaboration.
- enable deasserted mid-frame: the current frame completes and is released; no new frame starts.
- frame_available or buffer_ready changing after the frame starts: ignored until IDLE.
- frame_available already high on return to IDLE: the next frame may start on the next cycle.
- Reset mid-frame: returns to IDLE with no read_en pulse. The buffer still holds the frame, and after reset it is re-read from address 0.

Decomposition:
- Shared package mel_pkg holds:
  - state encoding (IDLE/READ/DRAIN/RELEASE);
  - the COEF_WIDTH Q-format localparam and the rounding-constant function;
  - the Hann coefficient function (real cos, evaluated at elaboration).
- One sub-module, win_coef_rom:
  - parameters WIN_LEN, COEF_WIDTH;
  - combinational address input, registered coefficient output;
  - instantiated once and clocked with adv as its enable.

Test Plan:
Bench parameters: WIN_LEN=8, DATA_WIDTH=16, COEF_WIDTH=16; coef = {0, 4799, 16384, 27969, 32768, 27969, 16384, 4799}.
- Constant frame: buf_data=1000 at every address, m_ready=1 -> m_data = {0, 146, 500, 854, 1000, 854, 500, 146}; m_last only on the 8th beat; one read_en pulse 1 cycle after the last beat; frame_count=1.
- Rounding: buf_data=3 at address 2 -> 2; buf_data=-3 at address 2 -> -1; buf_data=-32768 at address 4 -> -32768 with no saturation error.
- Backpressure: m_ready toggled 1,0,0,1,... -> data sequence identical to the no-stall case; m_data stable while stalled; read_addr holds during stalls; still exactly one read_en pulse.
- Gating:
  - frame_available=1, buffer_ready=0 -> stays IDLE, busy=0, no read.
  - enable=0 -> no start.
  - enable dropped at beat 3 -> frame completes, then no restart.
- Reset at beat 5 (rst=1 for 2 cycles) -> outputs go to reset values immediately, no read_en; after release, the frame is re-read from address 0 and frame_count=1 after it completes.
- Back-to-back: frame_available held high across 3 frames -> 3 read_en pulses, frame_count=3, each new frame starts 1 cycle after RELEASE.

Source files
------------

// File: rtl/mel_pkg.sv
// mel_pkg: shared FSM encoding, Q-format constants and Hann coefficient helpers
package mel_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;

    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = COEF_W - 1;

    // Half an LSB of the Q1.(coef_width-1) product, added before the final shift
    function automatic int round_const(input int coef_width);
        return 1 << (coef_width - 2);
    endfunction

    // Periodic Hann: round(2^(cw-1) * (0.5 - 0.5*cos(2*pi*n/N)))
    function automatic int hann_coef(input int n, input int win_len, input int coef_width);
        real scale;
        real x;
        scale = real'(1 << (coef_width - 1));
        x = scale * (0.5 - 0.5 * $cos(2.0 * 3.141592653589793 * real'(n) / real'(win_len)));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/win_coef_rom.sv
// win_coef_rom: Hann coefficient table with a registered, enable-gated output
module win_coef_rom
    import mel_pkg::*;
#(
    parameter int WIN_LEN    = 480,
    parameter int COEF_WIDTH = COEF_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [$clog2(WIN_LEN)-1:0] addr,
    output logic [COEF_WIDTH-1:0]      coef
);

    logic [COEF_WIDTH-1:0] rom [WIN_LEN];
    logic [COEF_WIDTH-1:0] coef_q, coef_d;

    for (genvar i = 0; i < WIN_LEN; i++) begin : g_rom
        assign rom[i] = COEF_WIDTH'(hann_coef(i, WIN_LEN, COEF_WIDTH));
    end

    // Look up the coefficient only when the pipeline advances
    always_comb begin
        coef_d = en ? rom[addr] : coef_q;
    end

    // Coefficient output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coef_q <= '0;
        else     coef_q <= coef_d;
    end

    assign coef = coef_q;

endmodule

// File: rtl/win_frame_reader.sv
// win_frame_reader: reads one buffered frame, applies a Hann window, streams it out
module win_frame_reader
    import mel_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int WIN_LEN         = 480,
    parameter int COEF_WIDTH      = COEF_W,
    parameter int ADDR_WIDTH      = $clog2(WIN_LEN),
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       frame_available,
    input  logic                       buffer_ready,
    input  logic [DATA_WIDTH-1:0]      buf_data,
    output logic                       read_en,
    output logic [ADDR_WIDTH-1:0]      read_addr,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int RW = PW - (COEF_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIN_LEN - 1);

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      s1_data_q, s1_data_d;
    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_last_q, s1_last_d;
    logic [COEF_WIDTH-1:0]      s1_coef;
    logic [DATA_WIDTH-1:0]      m_data_q, m_data_d;
    logic                       m_valid_q, m_valid_d;
    logic                       m_last_q, m_last_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       adv;
    logic signed [PW-1:0]       prod, prod_rnd;
    logic signed [RW-1:0]       shifted;
    logic                       ovf;
    logic [DATA_WIDTH-1:0]      sat;

    assign adv = !m_valid_q || m_ready;

    win_coef_rom #(
        .WIN_LEN   (WIN_LEN),
        .COEF_WIDTH(COEF_WIDTH)
    ) u_rom (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .addr(addr_q),
        .coef(s1_coef)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: the frame is released only once its last beat has been accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && frame_available && buffer_ready) state_d = READ;
            READ:    if (adv && addr_q == LAST) state_d = DRAIN;
            DRAIN:   if (m_valid_q && m_ready && m_last_q) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        read_en = (state_q == RELEASE);
        busy    = (state_q != IDLE);
    end

    // Window multiply, round half toward +inf, saturate to the sample range
    always_comb begin
        prod     = PW'($signed(s1_data_q)) * PW'($signed({1'b0, s1_coef}));
        prod_rnd = prod + PW'(round_const(COEF_WIDTH));
        shifted  = RW'(prod_rnd >>> (COEF_WIDTH - 1));
        ovf      = shifted[RW-1:DATA_WIDTH-1] != {(RW-DATA_WIDTH+1){shifted[RW-1]}};
        sat      = ovf ? {shifted[RW-1], {(DATA_WIDTH-1){~shifted[RW-1]}}} : shifted[DATA_WIDTH-1:0];
    end

    // Address walk and two-stage pipeline, all frozen while the output is stalled
    always_comb begin
        addr_d      = (state_q == RELEASE) ? '0 :
                      (state_q == READ && adv && addr_q != LAST) ? addr_q + 1'b1 : addr_q;
        s1_data_d   = adv ? buf_data : s1_data_q;
        s1_valid_d  = adv ? (state_q == READ) : s1_valid_q;
        s1_last_d   = adv ? (addr_q == LAST) : s1_last_q;
        m_data_d    = adv ? sat : m_data_q;
        m_valid_d   = adv ? s1_valid_q : m_valid_q;
        m_last_d    = adv ? (s1_valid_q && s1_last_q) : m_last_q;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(state_q == RELEASE);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            addr_q      <= addr_d;
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign read_addr   = addr_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_win_frame_reader.sv
// tb_win_frame_reader: scoreboard bench for the windowed frame reader
module tb_win_frame_reader;

    typedef struct packed {
        logic               l;
        logic signed [15:0] d;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               frame_available;
    logic               buffer_ready;
    logic signed [15:0] buf_data;
    logic               read_en;
    logic [2:0]         read_addr;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic               busy;
    logic [15:0]        frame_count;

    logic signed [15:0] buf_mem [8];
    int                 coef [8] = '{0, 4799, 16384, 27969, 32768, 27969, 16384, 4799};
    bit                 pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t               exp_q [$];
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 n_rel = 0;
    int                 beats = 0;
    int                 cyc = 0;
    int                 last_cyc = -10;
    bit                 bp_mode = 1'b0;
    bit                 stalled = 1'b0;
    logic signed [15:0] hold_data;
    logic [2:0]         hold_addr;

    win_frame_reader #(
        .DATA_WIDTH(16),
        .WIN_LEN(8),
        .COEF_WIDTH(16),
        .ADDR_WIDTH(3),
        .FRAME_CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .frame_available(frame_available),
        .buffer_ready(buffer_ready),
        .buf_data(buf_data),
        .read_en(read_en),
        .read_addr(read_addr),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign buf_data = buf_mem[read_addr];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic signed [15:0] wmodel(input int x, input int c);
        longint v;
        v = (longint'(x) * longint'(c) + 64'sd16384) >>> 15;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic push_frame();
        for (int i = 0; i < 8; i++) exp_q.push_back('{l: (i == 7), d: wmodel(int'(buf_mem[i]), coef[i])});
    endtask

    task automatic wait_release(input int cnt);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!read_en && t < 200);
        if (!read_en) check("rel_timeout", 0, 1);
        @(negedge clk);
        check("rel_pulse", read_en, 0);
        check("frame_count", frame_count, cnt);
    endtask

    task automatic wait_beats(input int target);
        int t = 0;
        while (beats < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (beats < target) check("beat_timeout", beats, target);
    endtask

    task automatic run_frame(input int cnt, input bit lat);
        push_frame();
        @(posedge clk); #1;
        frame_available = 1'b1;
        @(posedge clk); #1;
        frame_available = 1'b0;
        if (lat) begin
            @(negedge clk);
            @(negedge clk);
            check("lat_early", m_valid, 0);
            @(negedge clk);
            check("lat_first", m_valid, 1);
        end
        wait_release(cnt);
        check("sb_drain", exp_q.size(), 0);
    endtask

    task automatic idle_watch(input string tag);
        bit seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= busy | m_valid | read_en;
        end
        check(tag, seen, 0);
    endtask

    // m_ready driver: always ready, or the 1,0,0,1 stall pattern
    initial begin
        int k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                m_ready = pat[k];
                k = (k + 1) % 4;
            end else m_ready = 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, release timing
    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            if (stalled) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
                check("hold_addr", read_addr, hold_addr);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("sb_empty", 0, 1);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.d);
                    check("m_last", m_last, e.l);
                end
                beats++;
                if (m_last) last_cyc = cyc;
            end
            if (read_en) begin
                n_rel++;
                check("rel_gap", cyc, last_cyc + 1);
            end
            stalled   = m_valid && !m_ready;
            hold_data = m_data;
            hold_addr = read_addr;
        end
    end

    initial begin
        int base;
        int rel0;
        rst = 1'b1;
        enable = 1'b0;
        frame_available = 1'b0;
        buffer_ready = 1'b0;
        for (int i = 0; i < 8; i++) buf_mem[i] = 16'sd1000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_en", read_en, 0);
        check("rst_read_addr", read_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        rst = 1'b0;

        enable = 1'b1;
        frame_available = 1'b1;
        idle_watch("gate_no_buffer");
        check("gate_addr", read_addr, 0);
        enable = 1'b0;
        buffer_ready = 1'b1;
        idle_watch("gate_disabled");
        frame_available = 1'b0;
        enable = 1'b1;
        check("gate_rel", n_rel, 0);

        run_frame(1, 1'b1);

        for (int i = 0; i < 8; i++) buf_mem[i] = 16'sd0;
        buf_mem[2] = 16'sd3;
        buf_mem[4] = -16'sd32768;
        run_frame(2, 1'b0);
        buf_mem[2] = -16'sd3;
        buf_mem[4] = 16'sd32767;
        buf_mem[6] = -16'sd1;
        run_frame(3, 1'b0);

        for (int i = 0; i < 8; i++) buf_mem[i] = 16'($urandom);
        bp_mode = 1'b1;
        rel0 = n_rel;
        run_frame(4, 1'b0);
        check("bp_rel_once", n_rel, rel0 + 1);
        bp_mode = 1'b0;
        @(negedge clk);

        push_frame();
        base = beats;
        @(posedge clk); #1;
        frame_available = 1'b1;
        wait_beats(base + 3);
        enable = 1'b0;
        wait_release(5);
        idle_watch("en_drop_norestart");
        frame_available = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 8; i++) buf_mem[i] = 16'sd100 * 16'(i + 1);
        push_frame();
        base = beats;
        rel0 = n_rel;
        @(posedge clk); #1;
        frame_available = 1'b1;
        wait_beats(base + 5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_read_en", read_en, 0);
        check("mid_rst_addr", read_addr, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", frame_count, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        push_frame();
        wait_release(1);
        frame_available = 1'b0;
        check("mid_rst_rel", n_rel, rel0 + 1);
        check("mid_rst_sb", exp_q.size(), 0);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) buf_mem[i] = 16'($urandom);
        rel0 = n_rel;
        repeat (3) push_frame();
        frame_available = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_release(k);
            if (k == 3) frame_available = 1'b0;
            else begin
                check("b2b_idle", busy, 0);
                @(negedge clk);
                check("b2b_restart", busy, 1);
            end
        end
        idle_watch("b2b_stop");
        check("b2b_rel", n_rel, rel0 + 3);
        check("b2b_sb", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
